// File: rtl/route_vc_alloc_if.sv
// rtl/route_vc_alloc_if.sv - AXI-Stream bundle of N lanes with master/slave modports
interface route_vc_alloc_if #(
  parameter int N      = 1,
  parameter int DATA_W = 40,
  parameter int TID_W  = 4
);
  logic [N-1:0]             tvalid;
  logic [N-1:0]             tready;
  logic [N-1:0]             tlast;
  logic [N-1:0][TID_W-1:0]  tid;
  logic [N-1:0][DATA_W-1:0] tdata;

  modport master (output tvalid, tlast, tid, tdata, input tready);
  modport slave  (input tvalid, tlast, tid, tdata, output tready);
endinterface

// File: rtl/route_vc_alloc.sv
// rtl/route_vc_alloc.sv - Y-then-X routing and round-robin VC allocation for one input (option: ROUTE_ERR_CNT_EN)
module route_vc_alloc #(
  parameter int AXIS_DATA_WIDTH = 40,
  parameter int TID_WIDTH       = 4,
  parameter int ROUTING_HEADER  = 1,
  parameter int VC_NUM          = 2,
  parameter int CHANNEL_NUMBER  = 5 * VC_NUM,
  parameter int MAX_ROUTERS_X   = 4,
  parameter int MAX_ROUTERS_Y   = 4,
  parameter int ROUTER_X        = 0,
  parameter int ROUTER_Y        = 0,
  localparam int XW             = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1,
  localparam int YW             = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  route_vc_alloc_if.slave           in_axis_i,
  route_vc_alloc_if.master          out_axis_o,
  input  logic [CHANNEL_NUMBER-1:0] vc_busy_i,
  output logic [CHANNEL_NUMBER-1:0] vc_claim_o,
  input  logic [XW-1:0]             target_x_i,
  input  logic [YW-1:0]             target_y_i,
`ifdef ROUTE_ERR_CNT_EN
  output logic [15:0]               err_cnt_o,
`endif
  output logic                      err_o
);

  localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int CH_W = $clog2(CHANNEL_NUMBER);

  typedef enum logic {IDLE, FWD} state_t;

  state_t                      state_q;
  logic [CH_W-1:0]             sel_ch_q;
  logic [CHANNEL_NUMBER-1:0]   claim_q;
  logic [4:0][VC_W-1:0]        rr_ptr_q;
  logic                        err_q;

  logic [2:0]      dir;
  logic            is_hdr;
  logic            cand_found;
  logic [VC_W-1:0] cand_vc;
  logic [VC_W-1:0] rr_next;
  logic            route_en;
  logic [CH_W-1:0] route_ch;
  logic            in_ready;
  logic            drop_err;

  assign is_hdr = (in_axis_i.tid[0] == TID_WIDTH'(ROUTING_HEADER));

  // Dimension-order route: resolve Y first, then X, else deliver locally
  always_comb begin
    dir = 3'd0;
    if (target_y_i < YW'(ROUTER_Y))      dir = 3'd1;
    else if (target_y_i > YW'(ROUTER_Y)) dir = 3'd3;
    else if (target_x_i > XW'(ROUTER_X)) dir = 3'd2;
    else if (target_x_i < XW'(ROUTER_X)) dir = 3'd4;
  end

  // First free VC in the target direction, scanning from that direction's round-robin pointer
  always_comb begin
    logic [CH_W-1:0] ci;
    int              idx;
    cand_found = 1'b0;
    cand_vc    = '0;
    ci         = '0;
    idx        = 0;
    for (int k = 0; k < VC_NUM; k++) begin
      idx = (int'(rr_ptr_q[dir]) + k) % VC_NUM;
      ci  = CH_W'(int'(dir) * VC_NUM + idx);
      if (!cand_found && !vc_busy_i[ci] && !claim_q[ci]) begin
        cand_found = 1'b1;
        cand_vc    = VC_W'(idx);
      end
    end
  end

  assign rr_next = (cand_vc == VC_W'(VC_NUM - 1)) ? '0 : cand_vc + 1'b1;

  // Pick the output channel and the TREADY source for this cycle; a held channel wins over allocation
  always_comb begin
    route_en = 1'b0;
    route_ch = '0;
    in_ready = 1'b0;
    drop_err = 1'b0;
    if (rst_n_i) begin
      if (state_q == FWD) begin
        route_en = 1'b1;
        route_ch = sel_ch_q;
        in_ready = out_axis_o.tready[sel_ch_q];
      end else if (in_axis_i.tvalid[0]) begin
        if (is_hdr) begin
          if (cand_found) begin
            route_en = 1'b1;
            route_ch = CH_W'(int'(dir) * VC_NUM + int'(cand_vc));
            in_ready = out_axis_o.tready[route_ch];
          end
        end else begin
          in_ready = 1'b1;
          drop_err = 1'b1;
        end
      end
    end
  end

  assign in_axis_i.tready = in_ready;

  // Steer the input flit onto the chosen channel only; every other channel stays all-zero
  always_comb begin
    out_axis_o.tvalid = '0;
    out_axis_o.tlast  = '0;
    out_axis_o.tid    = '0;
    out_axis_o.tdata  = '0;
    if (route_en) begin
      out_axis_o.tvalid[route_ch] = in_axis_i.tvalid[0];
      out_axis_o.tlast[route_ch]  = in_axis_i.tlast[0];
      out_axis_o.tid[route_ch]    = in_axis_i.tid[0];
      out_axis_o.tdata[route_ch]  = in_axis_i.tdata[0];
    end
  end

  // Packet FSM: claim the VC on a multi-flit header, release it on the TLAST handshake
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      sel_ch_q <= '0;
      claim_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= drop_err;
      case (state_q)
        IDLE: begin
          if (in_axis_i.tvalid[0] && is_hdr && cand_found && in_ready) begin
            rr_ptr_q[dir] <= rr_next;
            if (!in_axis_i.tlast[0]) begin
              sel_ch_q <= route_ch;
              claim_q  <= CHANNEL_NUMBER'(1) << route_ch;
              state_q  <= FWD;
            end
          end
        end
        FWD: begin
          if (in_axis_i.tvalid[0] && in_ready && in_axis_i.tlast[0]) begin
            claim_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vc_claim_o = claim_q;
  assign err_o      = err_q;

`ifdef ROUTE_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Saturating error count, updated on the same edge that raises err_o
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt_q <= '0;
    end else if (drop_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_route_vc_alloc.sv
// tb/tb_route_vc_alloc.sv - randomized bench for route_vc_alloc against a packet-level reference model
module tb_route_vc_alloc;
  localparam int VC  = 2;
  localparam int CH  = 5 * VC;
  localparam int DW  = 40;
  localparam int TW  = 4;
  localparam int HDR = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  route_vc_alloc_if #(.N(1),  .DATA_W(DW), .TID_W(TW)) in_if ();
  route_vc_alloc_if #(.N(CH), .DATA_W(DW), .TID_W(TW)) out_if ();

  logic [CH-1:0] vc_busy, vc_claim;
  logic [1:0]    target_x, target_y;
  logic          err;
`ifdef ROUTE_ERR_CNT_EN
  logic [15:0]   err_cnt;
`endif

  route_vc_alloc #(
    .AXIS_DATA_WIDTH(DW), .TID_WIDTH(TW), .ROUTING_HEADER(HDR), .VC_NUM(VC),
    .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4), .ROUTER_X(1), .ROUTER_Y(1)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_axis_i(in_if), .out_axis_o(out_if),
    .vc_busy_i(vc_busy), .vc_claim_o(vc_claim),
    .target_x_i(target_x), .target_y_i(target_y),
`ifdef ROUTE_ERR_CNT_EN
    .err_cnt_o(err_cnt),
`endif
    .err_o(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stimulus held in bench variables; the model reads only these
  logic          vld, last, rstn;
  logic [TW-1:0] tid;
  logic [1:0]    tx, ty;
  logic [CH-1:0] busy, ordy;
  logic [DW-1:0] data;

  // Reference state: owned channel (-1 when no packet open), per-direction next VC, pending error
  int          own;
  int          m_rr[5];
  logic        m_err;
  int          m_cnt;

  logic [CH-1:0] obs_tv, obs_claim;
  logic          obs_rdy, obs_err;

  function automatic int route_dir(input int x, input int y);
    if (y < 1) return 1;
    if (y > 1) return 3;
    if (x > 1) return 2;
    if (x < 1) return 4;
    return 0;
  endfunction

  task automatic cycle();
    int            ech, d, v, t;
    logic          erdy;
    logic [63:0]   exp_e, got_e;
    logic [CH-1:0] eclaim;
    in_if.tvalid[0] = vld;
    in_if.tlast[0]  = last;
    in_if.tid[0]    = tid;
    in_if.tdata[0]  = data;
    out_if.tready   = ordy;
    vc_busy         = busy;
    target_x        = tx;
    target_y        = ty;
    rst_n           = rstn;
    #4;
    if (!rstn) begin
      own = -1;
      for (int i = 0; i < 5; i++) m_rr[i] = 0;
      m_err = 1'b0;
      m_cnt = 0;
    end
    ech = -1; erdy = 1'b0; d = 0; v = 0;
    if (rstn) begin
      if (own >= 0) begin
        ech  = own;
        erdy = ordy[own];
      end else if (vld) begin
        if (tid == HDR) begin
          d = route_dir(int'(tx), int'(ty));
          for (int k = 0; k < VC; k++) begin
            t = (m_rr[d] + k) % VC;
            if (ech < 0 && !busy[d * VC + t]) begin
              ech = d * VC + t;
              v   = t;
            end
          end
          if (ech >= 0) erdy = ordy[ech];
        end else begin
          erdy = 1'b1;
        end
      end
    end
    check("tready", 64'(in_if.tready[0]), 64'(erdy));
    for (int c = 0; c < CH; c++) begin
      exp_e = (c == ech) ? 64'({vld, last, tid, data}) : 64'd0;
      got_e = 64'({out_if.tvalid[c], out_if.tlast[c], out_if.tid[c], out_if.tdata[c]});
      check($sformatf("out_ch%0d", c), got_e, exp_e);
    end
    eclaim = (own >= 0) ? (CH'(1) << own) : '0;
    check("claim", 64'(vc_claim), 64'(eclaim));
    check("err", 64'(err), 64'(m_err));
`ifdef ROUTE_ERR_CNT_EN
    check("err_cnt", 64'(err_cnt), 64'(m_cnt));
`endif
    obs_tv    = out_if.tvalid;
    obs_claim = vc_claim;
    obs_rdy   = in_if.tready[0];
    obs_err   = err;
    m_err = rstn && own < 0 && vld && tid != HDR;
    if (m_err && m_cnt < 65535) m_cnt++;
    if (rstn && vld && erdy) begin
      if (own >= 0) begin
        if (last) own = -1;
      end else if (ech >= 0) begin
        m_rr[d] = (v + 1) % VC;
        if (!last) own = ech;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic flit(input logic fv, input logic [TW-1:0] ft, input logic fl,
                      input logic [1:0] fx, input logic [1:0] fy);
    vld = fv; tid = ft; last = fl; tx = fx; ty = fy;
    data = {$urandom, $urandom};
    cycle();
  endtask

  initial begin
    own = -1; m_err = 1'b0; m_cnt = 0;
    for (int i = 0; i < 5; i++) m_rr[i] = 0;
    rstn = 1'b0; vld = 1'b0; last = 1'b0; tid = '0; tx = '0; ty = '0;
    busy = '0; ordy = '1; data = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cycle();
    check("rst_claim", 64'(obs_claim), 64'd0);
    check("rst_tv", 64'(obs_tv), 64'd0);
    check("rst_rdy", 64'(obs_rdy), 64'd0);
    cycle();
    rstn = 1'b1;

    // Local delivery, held for 3 body flits then released
    flit(1'b1, TW'(HDR), 1'b0, 2'd1, 2'd1);
    check("t1_hdr_ch0", 64'(obs_tv), 64'h001);
    flit(1'b1, 4'd0, 1'b0, 2'd0, 2'd0);
    check("t1_claim", 64'(obs_claim), 64'h001);
    flit(1'b1, 4'd3, 1'b0, 2'd0, 2'd0);
    flit(1'b1, 4'd0, 1'b1, 2'd0, 2'd0);
    flit(1'b0, 4'd0, 1'b0, 2'd0, 2'd0);
    check("t1_released", 64'(obs_claim), 64'd0);

    // Y before X, round-robin within dir 1
    for (int p = 0; p < 3; p++) begin
      flit(1'b1, TW'(HDR), 1'b0, 2'd3, 2'd0);
      check($sformatf("t2_pkt%0d", p), 64'(obs_tv), (p == 1) ? 64'h008 : 64'h004);
      flit(1'b1, 4'd0, 1'b1, 2'd0, 2'd0);
    end

    // Both dir-1 VCs busy: stall, then go as soon as one frees
    busy = 10'h00C;
    for (int i = 0; i < 5; i++) begin
      flit(1'b1, TW'(HDR), 1'b0, 2'd3, 2'd0);
      check("t3_stall", 64'({obs_rdy, obs_tv}), 64'd0);
    end
    busy = 10'h004;
    flit(1'b1, TW'(HDR), 1'b0, 2'd3, 2'd0);
    check("t3_go_ch3", 64'({obs_rdy, obs_tv}), {53'd0, 1'b1, 10'h008});
    flit(1'b1, 4'd0, 1'b1, 2'd0, 2'd0);
    busy = '0;

    // Body flit while idle is swallowed and flagged
    flit(1'b1, 4'd2, 1'b0, 2'd0, 2'd0);
    check("t4_drop", 64'({obs_rdy, obs_tv}), {53'd0, 1'b1, 10'h000});
    flit(1'b0, 4'd0, 1'b0, 2'd0, 2'd0);
    check("t4_err", 64'(obs_err), 64'd1);

    // Reset mid-packet, then a stray body flit
    flit(1'b1, TW'(HDR), 1'b0, 2'd1, 2'd1);
    flit(1'b1, 4'd0, 1'b0, 2'd0, 2'd0);
    rstn = 1'b0;
    flit(1'b1, 4'd0, 1'b0, 2'd0, 2'd0);
    check("t5_rst", 64'({obs_claim, obs_tv}), 64'd0);
    rstn = 1'b1;
    flit(1'b1, 4'd0, 1'b0, 2'd0, 2'd0);
    flit(1'b0, 4'd0, 1'b0, 2'd0, 2'd0);
    check("t5_err", 64'(obs_err), 64'd1);

    // Single-flit packets to dir 2 advance the pointer without claiming
    flit(1'b1, TW'(HDR), 1'b1, 2'd3, 2'd1);
    check("t6_ch4", 64'({obs_claim, obs_tv}), 64'h010);
    flit(1'b1, TW'(HDR), 1'b1, 2'd2, 2'd1);
    check("t6_ch5", 64'(obs_tv), 64'h020);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      rstn = ($urandom_range(0, 199) != 0);
      vld  = ($urandom_range(0, 3) != 0);
      if (own < 0) tid = ($urandom_range(0, 5) == 0) ? 4'd2 : TW'(HDR);
      else         tid = TW'($urandom_range(0, 3));
      last = ($urandom_range(0, 3) == 0);
      tx   = 2'($urandom_range(0, 3));
      ty   = 2'($urandom_range(0, 3));
      busy = CH'($urandom & $urandom);
      ordy = ~CH'($urandom & $urandom & $urandom);
      data = {$urandom, $urandom};
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/route_vc_alloc.md
# route_vc_alloc

Per-input routing and virtual-channel allocation stage of the mesh router. It takes one input AXI-Stream, computes the output direction from the header's target coordinates using Y-then-X dimension order, and allocates a free virtual channel (VC) in that direction with per-direction round-robin. It holds that channel for the whole packet and releases it on TLAST. Each router input port instantiates one; its outputs feed the per-output-channel arbiters.

## Interface
- AXIS_DATA_WIDTH, 40: payload width carried inside axis_mosi_t.
- VC_NUM, 2: VCs per direction (1..8); VC_WIDTH = max(1, $clog2(VC_NUM)).
- CHANNEL_NUMBER, 5*VC_NUM: output channels; index = dir*VC_NUM + vc. Dir 0 local, 1 y-minus, 2 x-plus, 3 y-plus, 4 x-minus.
- MAX_ROUTERS_X / MAX_ROUTERS_Y, 4 / 4: mesh size; coordinate widths are $clog2 of each.
- ROUTER_X / ROUTER_Y, 0 / 0: this router's coordinates.
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- in_mosi_i  in  axis_mosi_t  input stream (TVALID, data.TID, data.TLAST, payload).
- in_miso_o  out  axis_miso_t  input TREADY.
- out_mosi_o  out  axis_mosi_t [CHANNEL_NUMBER]  per-channel output stream.
- out_miso_i  in  axis_miso_t [CHANNEL_NUMBER]  per-channel TREADY.
- vc_busy_i  in  CHANNEL_NUMBER  external occupancy: channel is held by another input.
- vc_claim_o  out  CHANNEL_NUMBER  one-hot, or zero: channel held by this input.
- target_x_i / target_y_i  in  coordinate widths  header destination; valid only with a header flit.
- err_o  out  1  one-cycle pulse on a protocol error.

## Operation
- Direction is decided in this order: y<ROUTER_Y gives dir 1; y>ROUTER_Y gives dir 3; otherwise x>ROUTER_X gives dir 2; x<ROUTER_X gives dir 4; otherwise dir 0.
- A header is a flit with data.TID == ROUTING_HEADER.
- State machine: IDLE, FWD.
- IDLE, TVALID with a header:
  - Candidate VCs are those in the target direction not set in vc_busy_i and not claimed by this block.
  - Pick the first candidate at or after rr_ptr[dir], wrapping mod VC_NUM.
  - If there is no candidate, TREADY=0, nothing is driven, and the block stays in IDLE. It re-evaluates every cycle.
  - Otherwise drive the flit to the chosen channel and pass that channel's TREADY back.
- Header handshake (TVALID & TREADY), not TLAST:
  - Register sel_ch and set vc_claim_o[sel_ch].
  - rr_ptr[dir] <= chosen vc + 1 mod VC_NUM.
  - Go to FWD.
- Header handshake with TLAST (single-flit packet): rr_ptr advances, no claim, stay in IDLE.
- IDLE, TVALID with a non-header flit: protocol error. TREADY=1, the flit is dropped (not forwarded), err_o pulses the next cycle.
- FWD: every flit goes to sel_ch regardless of TID, and in_miso_o.TREADY = out_miso_i[sel_ch].TREADY. vc_busy_i is ignored for the held channel.
- FWD, TLAST handshake: clear the claim, go to IDLE. A header arriving in the following cycle is allocated normally.
- Non-selected out_mosi_o entries are driven all-zero at all times.

## Timing
- Reset values:
  - State IDLE, all rr_ptr 0, sel_ch 0.
  - vc_claim_o 0, err_o 0, in_miso_o all zero.
  - out_mosi_o all zero.
- Latency:
  - Forwarding is combinational, zero-cycle, in both states.
  - Claim and state update one cycle after the handshake.
- Allocation depends on registered state and vc_busy_i in the same cycle. vc_busy_i must not combinationally depend on vc_claim_o of this block within a cycle.
- TVALID held without TREADY keeps the channel choice stable, unless vc_busy_i changes. Re-selection is allowed only while IDLE.
- Reset mid-packet: immediate return to reset values. The remainder of the packet is then treated as protocol error flits.
- Simultaneous TLAST handshake and a new header in the same cycle is impossible: one flit per cycle.

## Configuration
- ROUTE_ERR_CNT_EN defined:
  - Adds output err_cnt_o [15:0]: a saturating count of protocol errors, reset to 0.
  - The count increments in the same cycle err_o is asserted and holds at 16'hFFFF.
- ROUTE_ERR_CNT_EN undefined: the port and counter are absent. err_o is unaffected.

## Test plan
- Header at ROUTER(1,1) with target (1,1), VC_NUM=2, all free -> channel 0 receives the flit; after 3 body flits with TLAST, vc_claim_o returns to 0.
- Target (3,0) at (1,1) -> dir 1 (Y first), channel 2. A second packet -> channel 3 via round-robin. A third -> channel 2.
- vc_busy_i[2] and [3] set, header to dir 1 -> TREADY=0 for 5 cycles. Clear bit 3 -> flit forwarded to channel 3 that cycle.
- Body flit in IDLE -> TREADY=1, no out_mosi_o activity, err_o pulse. With ROUTE_ERR_CNT_EN, err_cnt_o goes 0->1.
- rst_n_i asserted mid-packet in FWD -> vc_claim_o=0 and out_mosi_o zero immediately. The next body flit raises err_o.
- Single-flit header+TLAST to dir 2 -> forwarded on channel 4, no claim, rr_ptr[2]=1.
